button_event_fsm: RTL and testbench



---
 rtl/button_event_fsm.sv | 103 ++++++++++
 tb/tb_button_event_fsm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_fsm.sv
// Turns a debounced, clk-synchronous button level into single-cycle press/release/click/long/repeat
// events, plus a held level and a wrapping press counter. All outputs are registered.
module button_event_fsm #(
    parameter int unsigned LONG_CYCLES   = 16,
    parameter int unsigned REPEAT_CYCLES = 4,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       button_state,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       click_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {StIdle, StPress, StLong} state_e;

    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 2);
    localparam logic [CNT_W-1:0] RepLast  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    state_e           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            cnt           <= '0;
            press_count   <= 8'd0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            if (!en) begin
                state <= StIdle;
                cnt   <= '0;
                held  <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (button_state) begin
                            press_pulse <= 1'b1;
                            press_count <= press_count + 8'd1;
                            cnt         <= '0;
                            state       <= StPress;
                            held        <= 1'b1;
                        end
                    end
                    StPress: begin
                        // Release takes priority over the long-press terminal count.
                        if (!button_state) begin
                            release_pulse <= 1'b1;
                            click_pulse   <= 1'b1;
                            state         <= StIdle;
                            held          <= 1'b0;
                        end else if (cnt == LongLast) begin
                            long_pulse <= 1'b1;
                            cnt        <= '0;
                            state      <= StLong;
                        end else begin
                            cnt <= cnt + CntOne;
                        end
                    end
                    StLong: begin
                        if (!button_state) begin
                            release_pulse <= 1'b1;
                            state         <= StIdle;
                            held          <= 1'b0;
                        end else if (cnt == RepLast) begin
                            // Without repeat the counter simply parks at its terminal value.
                            if (REPEAT_EN) begin
                                repeat_pulse <= 1'b1;
                                cnt          <= '0;
                            end
                        end else begin
                            cnt <= cnt + CntOne;
                        end
                    end
                    default: begin
                        state <= StIdle;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_event_fsm.sv
// Directed bench for button_event_fsm: default instance plus a REPEAT_EN = 0 instance on shared stimulus.
module tb_button_event_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       button_state;
    logic       press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held;
    logic [7:0] press_count;
    logic       press2, release2, click2, long2, repeat2, held2;
    logic [7:0] count2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_press, n_rel, n_click, n_long, n_rep, n_held;
    int n2_long, n2_rep, n2_rel;
    int press_cyc, long_cyc, first_rep_cyc, viol;

    always #5 clk = ~clk;

    button_event_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .button_state  (button_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .click_pulse   (click_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held),
        .press_count   (press_count)
    );

    button_event_fsm #(.REPEAT_EN(1'b0)) dut_norep (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .button_state  (button_state),
        .press_pulse   (press2),
        .release_pulse (release2),
        .click_pulse   (click2),
        .long_pulse    (long2),
        .repeat_pulse  (repeat2),
        .held          (held2),
        .press_count   (count2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_press = 0; n_rel = 0; n_click = 0; n_long = 0; n_rep = 0; n_held = 0;
        n2_long = 0; n2_rep = 0; n2_rel = 0;
        press_cyc = -1; long_cyc = -1; first_rep_cyc = -1;
    endtask

    // Advance one edge, then observe that edge's registered outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (press_pulse) begin n_press++; press_cyc = cyc; end
        if (release_pulse) n_rel++;
        if (click_pulse) n_click++;
        if (long_pulse) begin n_long++; long_cyc = cyc; end
        if (repeat_pulse) begin
            n_rep++;
            if (first_rep_cyc < 0) first_rep_cyc = cyc;
        end
        if (held) n_held++;
        if (long2) n2_long++;
        if (repeat2) n2_rep++;
        if (release2) n2_rel++;
        if ((int'(press_pulse) + int'(long_pulse) + int'(repeat_pulse) > 1) ||
            (release_pulse && (press_pulse || long_pulse || repeat_pulse)) ||
            (click_pulse && !release_pulse))
            viol++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        viol = 0;
        clr();
        rst_n = 1'b0; en = 1'b1; button_state = 1'b1;
        #2;
        check("rst_pulses_async", int'({press_pulse, release_pulse, click_pulse, long_pulse,
                                        repeat_pulse}), 0);
        check("rst_held_async", int'(held), 0);
        check("rst_count_async", int'(press_count), 0);
        ticks(2);
        check("rst_pulses_clocked", int'({press_pulse, release_pulse, click_pulse, long_pulse,
                                          repeat_pulse, held}), 0);

        // Button already down when reset releases: first enabled edge is a press.
        rst_n = 1'b1;
        tick();
        check("rst_press_pulse", int'(press_pulse), 1);
        check("rst_press_count", int'(press_count), 1);
        check("rst_held", int'(held), 1);
        button_state = 1'b0;
        tick();
        check("rst_release_click", int'({release_pulse, click_pulse}), 3);

        // Short press: 3 sampled-high edges.
        clr();
        button_state = 1'b1;
        ticks(3);
        button_state = 1'b0;
        ticks(2);
        check("short_press_n", n_press, 1);
        check("short_release_n", n_rel, 1);
        check("short_click_n", n_click, 1);
        check("short_long_n", n_long, 0);
        check("short_held_cycles", n_held, 3);
        check("short_count", int'(press_count), 2);

        // Hold 30 cycles: long 15 after press, repeats every 4.
        clr();
        button_state = 1'b1;
        ticks(30);
        button_state = 1'b0;
        ticks(2);
        check("hold_long_delay", long_cyc - press_cyc, 15);
        check("hold_first_rep", first_rep_cyc - long_cyc, 4);
        check("hold_rep_n", n_rep, 3);
        check("hold_long_n", n_long, 1);
        check("hold_release_n", n_rel, 1);
        check("hold_click_n", n_click, 0);
        check("hold_count", int'(press_count), 3);

        // Release on the exact long-qualify edge.
        clr();
        button_state = 1'b1;
        ticks(15);
        button_state = 1'b0;
        tick();
        check("edge_release_click", int'({release_pulse, click_pulse, long_pulse}), 6);
        check("edge_held", int'(held), 0);
        tick();
        check("edge_long_n", n_long, 0);
        check("edge_idle_quiet", int'({press_pulse, release_pulse, held}), 0);

        // Hold 40: no-repeat instance gives one long and no repeats.
        clr();
        button_state = 1'b1;
        ticks(40);
        button_state = 1'b0;
        ticks(2);
        check("norep_long_n", n2_long, 1);
        check("norep_rep_n", n2_rep, 0);
        check("norep_release_n", n2_rel, 1);
        check("rep40_rep_n", n_rep, 6);
        check("rep40_count", int'(press_count), 5);

        // en dropped mid-hold, then raised while still pressed.
        clr();
        button_state = 1'b1;
        ticks(4);
        en = 1'b0;
        tick();
        check("en_off_held", int'(held), 0);
        check("en_off_release", int'(release_pulse), 0);
        ticks(3);
        check("en_off_press_n", n_press, 1);
        check("en_off_count", int'(press_count), 6);
        en = 1'b1;
        tick();
        check("en_on_press", int'(press_pulse), 1);
        check("en_on_count", int'(press_count), 7);
        button_state = 1'b0;
        tick();
        check("en_on_release_click", int'({release_pulse, click_pulse}), 3);

        // Wrap: reset, then 257 short presses.
        rst_n = 1'b0;
        #1;
        check("wrap_rst_count", int'(press_count), 0);
        ticks(1);
        rst_n = 1'b1;
        for (int i = 0; i < 257; i++) begin
            button_state = 1'b1;
            tick();
            button_state = 1'b0;
            tick();
        end
        check("wrap_count", int'(press_count), 1);

        check("exclusive_pulses", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
